// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the five-stage core.
// - Combinational stall arbitration (MEM > EX > ID > IF) into a 6-bit stall vector.
// - Combinational flush pulse and redirect PC, derived from the MEM exception type.
// - A post-flush GUARD window that ignores excepttype_i.
// - A sticky stall watchdog.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall-winner and flush performance counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          GUARD_CYCLES  = 2,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 16   // 2**CNT_W must exceed STALL_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        guard_o,
  output logic        stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_if,
  output logic [31:0] perf_stall_id,
  output logic [31:0] perf_stall_ex,
  output logic [31:0] perf_stall_mem,
  output logic [31:0] perf_flush
`endif
);

  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_GUARD = 1'b1;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // Wide enough to hold GUARD_CYCLES-1, and never zero bits wide.
  localparam int             GW         = $clog2(GUARD_CYCLES + 2);
  localparam logic [GW-1:0]  GUARD_INIT = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(STALL_TIMEOUT - 1);

  logic [0:0]       r_state;
  logic [GW-1:0]    r_guard_cnt;
  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_timeout;

  logic [5:0]       w_stall_arb;
  logic [3:0]       w_winner;   // one-hot: [0]=if, [1]=id, [2]=ex, [3]=mem
  logic             w_flush;
  logic             w_stalled;

  // Stall priority encoder: the highest-priority requester sets the freeze depth.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and infers a latch.
    w_stall_arb = 6'b000000;
    w_winner    = 4'b0000;
    if (stallreq_mem) begin
      w_stall_arb = 6'b011111;
      w_winner    = 4'b1000;
    end else if (stallreq_ex) begin
      w_stall_arb = 6'b001111;
      w_winner    = 4'b0100;
    end else if (stallreq_id) begin
      w_stall_arb = 6'b000111;
      w_winner    = 4'b0010;
    end else if (stallreq_if) begin
      w_stall_arb = 6'b000011;
      w_winner    = 4'b0001;
    end
  end

  // Exceptions are accepted only in RUN. A flush overrides any stall, and reset
  // forces every combinational output low.
  assign w_flush   = !rst && (r_state == ST_RUN) && (excepttype_i != 32'h0);
  assign stall     = (rst || w_flush) ? 6'b000000 : w_stall_arb;
  assign w_stalled = (stall != 6'b000000);
  assign flush     = w_flush;
  assign new_pc    = !w_flush                  ? 32'h0 :
                     (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;

  assign guard_o         = (r_state == ST_GUARD);
  assign stall_timeout_o = r_timeout;

  // RUN/GUARD sequencer: the guard lasts exactly GUARD_CYCLES cycles after a flush.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of the statements.
    if (rst) begin
      r_state     <= ST_RUN;
      r_guard_cnt <= '0;
    end else if (r_state == ST_GUARD) begin
      if (r_guard_cnt == '0) begin
        r_state <= ST_RUN;
      end else begin
        r_guard_cnt <= r_guard_cnt - 1'b1;
      end
    end else if (w_flush && (GUARD_CYCLES > 0)) begin
      r_state     <= ST_GUARD;
      r_guard_cnt <= GUARD_INIT;
    end
  end

  // Watchdog: counts consecutive stalled cycles (saturating) and latches a sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_stalled || w_flush) begin
        r_wd_cnt <= '0;
      end else if (r_wd_cnt != '1) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_stalled && (r_wd_cnt == WD_LAST)) begin
        r_timeout <= 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Performance counters: a winner is counted only when its stall actually takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_if  <= '0;
      perf_stall_id  <= '0;
      perf_stall_ex  <= '0;
      perf_stall_mem <= '0;
      perf_flush     <= '0;
    end else begin
      if (w_stalled && w_winner[0]) perf_stall_if  <= perf_stall_if  + 32'd1;
      if (w_stalled && w_winner[1]) perf_stall_id  <= perf_stall_id  + 32'd1;
      if (w_stalled && w_winner[2]) perf_stall_ex  <= perf_stall_ex  + 32'd1;
      if (w_stalled && w_winner[3]) perf_stall_mem <= perf_stall_mem + 32'd1;
      if (w_flush)                  perf_flush     <= perf_flush     + 32'd1;
    end
  end
`else
  // The winner vector only feeds the performance counters.
  logic w_unused;
  assign w_unused = ^w_winner;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the five-stage core.
- Arbitrates stall requests from the IF, ID, EX and MEM stages into the single 6-bit stall vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb).
- Converts the exception type reported from MEM into the pipeline flush pulse and the redirect PC.
- Sequences a post-flush guard window and a stall watchdog.

Parameters:
EXC_VECTOR, 32'h00000020, redirect PC for all exceptions except ERET
GUARD_CYCLES, 2, cycles after a flush during which excepttype_i is ignored (0 = no guard)
STALL_TIMEOUT, 1024, consecutive stalled cycles before watchdog fires
CNT_W, 16, watchdog counter width; must satisfy 2**CNT_W > STALL_TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stallreq_if  in  1  fetch stage stall request
stallreq_id  in  1  decode stage stall request (load-use)
stallreq_ex  in  1  execute stage stall request (mult/div)
stallreq_mem  in  1  memory stage stall request
excepttype_i  in  32  exception type from MEM; 0 = none
cp0_epc_i  in  32  current EPC value (already forwarded)
stall  out  6  stall vector; bit0 = pc … bit5 = wb
flush  out  1  pipeline flush, one cycle
new_pc  out  32  redirect address, valid while flush=1
guard_o  out  1  high while in GUARD state
stall_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=1 at posedge):
  - state=RUN; guard counter=0; watchdog counter=0; stall_timeout_o=0.
  - Combinational outputs are forced during rst: stall=0, flush=0, new_pc=0.
- Stall arbitration is combinational, with the same-cycle response required by the pipeline registers. Priority is MEM > EX > ID > IF:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- flush is combinational: flush = (state==RUN) && (excepttype_i != 0).
- new_pc while flush=1:
  - cp0_epc_i if excepttype_i == 32'h0000000e (ERET).
  - EXC_VECTOR for 32'h1 (int), 32'h8 (syscall), 32'ha (invalid inst), 32'hd (trap), 32'hc (overflow), and any other nonzero value.
  - new_pc = 0 when flush=0.
- Flush dominates stall: stall=0 in any cycle where flush=1.
- FSM:
  - RUN: on flush, if GUARD_CYCLES>0 → GUARD with guard counter=GUARD_CYCLES-1; else stay in RUN.
  - GUARD: guard_o=1, flush forced 0, excepttype_i ignored, stall arbitration still active. Counter decrements each cycle; at 0 → RUN.
  - Total GUARD duration is exactly GUARD_CYCLES cycles.
- Watchdog:
  - Counter increments each cycle with stall!=0.
  - Counter clears to 0 on any cycle with stall==0 or flush=1.
  - Counter saturates at all-ones.
  - When the counter equals STALL_TIMEOUT-1 and stall!=0, stall_timeout_o is set at the next edge. It stays set until rst.
- Reset mid-GUARD or mid-stall: all state returns to reset values at that edge. No residual flush.
- Simultaneous exception and any stall request in RUN: flush=1, stall=0, watchdog cleared.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds four 32-bit wrapping counters perf_stall_if/id/ex/mem, output ports in that order. Each increments on cycles where that source is the winning (highest-priority) stall requester. Adds a 32-bit perf_flush counter incremented per flush pulse. All counters clear on rst.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- rst=1 for 3 cycles with all requests and excepttype_i=32'h8 asserted → stall=0, flush=0, new_pc=0, stall_timeout_o=0; release rst → flush=1 the first cycle, new_pc=32'h20.
- stallreq_if=1, stallreq_ex=1 together → stall=6'b001111; drop ex → 6'b000011; drop all → 6'b000000.
- RUN, excepttype_i=32'he, cp0_epc_i=32'h00001234, stallreq_mem=1 → same cycle flush=1, new_pc=32'h00001234, stall=0; next 2 cycles guard_o=1; excepttype_i=32'hc held throughout gives flush=0 during guard, flush=1 on cycle 3.
- GUARD_CYCLES=0, excepttype_i=32'h1 held 3 cycles → flush=1 on all 3, new_pc=32'h20, guard_o never asserted.
- STALL_TIMEOUT=8, stallreq_id held 7 cycles then dropped → no timeout; held 8 cycles → stall_timeout_o=1 after the 8th edge, still 1 after request drops, clears only on rst.
- PIPE_CTRL_PERF_EN: 5 cycles of stallreq_if+stallreq_mem, 2 flushes → perf_stall_mem=5, perf_stall_if=0, perf_flush=2.
